aibcr3aux_osc_cal_ctrl: RTL and testbench

//  Power-up and trim-calibration sequencer for the AUX ring oscillator.
//  - Enables the oscillator and waits for all three vreg-ready bits.
//  - Binary-searches the 9-bit trim code against a target edge count measured over a fixed window.
//  - Releases the oscillator's ready-delay input when the final count is within tolerance.
//  - Sits beside the oscillator; drives its pdb/trim/rdy_dly inputs from the AUX config clock.

---
 rtl/aibcr3aux_osc_cal_pkg.sv | 26 ++
 rtl/aibcr3aux_osc_cal_meas.sv | 81 ++++++++
 rtl/aibcr3aux_osc_cal_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_aibcr3aux_osc_cal_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3aux_osc_cal_pkg.sv
// Shared types and constants for the AUX ring-oscillator calibration sequencer.
package aibcr3aux_osc_cal_pkg;

    localparam int TRIM_W         = 9;
    localparam logic [TRIM_W-1:0] TRIM_MID = 9'h100;

    localparam int WIN_CYC_DEF    = 1024;
    localparam int SETTLE_CYC_DEF = 64;
    localparam int VREG_TO_DEF    = 4096;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MEAS   = 3'd3,
        ST_DECIDE = 3'd4,
        ST_DONE   = 3'd5,
        ST_FAIL   = 3'd6
    } cal_state_e;

    function automatic logic is_busy(input cal_state_e s);
        return (s == ST_PWRUP) || (s == ST_SETTLE) || (s == ST_MEAS) || (s == ST_DECIDE);
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_cal_meas.sv
// Oscillator edge counter: synchronizes the divider toggle, detects its edges and
// counts them over a fixed window, saturating at all-ones.
module aibcr3aux_osc_cal_meas
    import aibcr3aux_osc_cal_pkg::*;
#(
    parameter int WIN_CYC = WIN_CYC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             osc_tgl,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int WIN_W = $clog2(WIN_CYC + 1);

    logic             sync1_q, sync2_q, sync3_q;
    logic             osc_edge;
    logic             active_q, active_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // sync1/sync2 form the synchronizer; sync3 only delays for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= osc_tgl;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign osc_edge = sync2_q ^ sync3_q;

    always_comb begin
        cnt_inc  = (osc_edge && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        done     = active_q && (timer_q == WIN_W'(WIN_CYC - 1));
        count    = cnt_inc;
        active_d = active_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        if (abort) begin
            active_d = 1'b0;
            timer_d  = '0;
            cnt_d    = '0;
        end else if (start) begin
            active_d = 1'b1;
            timer_d  = '0;
            cnt_d    = '0;
        end else if (active_q) begin
            if (done) begin
                active_d = 1'b0;
                timer_d  = '0;
                cnt_d    = '0;
            end else begin
                timer_d = timer_q + WIN_W'(1);
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            timer_q  <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/aibcr3aux_osc_cal_ctrl.sv
// AUX oscillator power-up and trim calibration: waits for the regulators, runs a
// 9-step successive-approximation trim search, then verifies the final count.
module aibcr3aux_osc_cal_ctrl
    import aibcr3aux_osc_cal_pkg::*;
#(
    parameter int WIN_CYC    = WIN_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int VREG_TO    = VREG_TO_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              i_cal_start,
    input  logic              i_fuse_bypass,
    input  logic [TRIM_W-1:0] i_fuse_trim,
    input  logic [CNT_W-1:0]  i_target,
    input  logic [7:0]        i_tol,
    input  logic [2:0]        i_vreg_rdy,
    input  logic              i_osc_tgl,
    output logic              o_pdb,
    output logic [TRIM_W-1:0] o_trim,
    output logic              o_rdy_dly,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic [CNT_W-1:0]  o_meas_cnt,
    output logic [2:0]        o_state
);

    localparam int TMR_W = $clog2(((VREG_TO > SETTLE_CYC) ? VREG_TO : SETTLE_CYC) + 1);

    cal_state_e        state_q, state_d;
    logic              pdb_q, pdb_d;
    logic [TRIM_W-1:0] trim_q, trim_d, trim_next;
    logic              rdy_dly_q, rdy_dly_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [CNT_W-1:0]  meas_cnt_q, meas_cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic              verify_q, verify_d;
    logic              bypass_q, bypass_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              meas_start, meas_abort, meas_done;
    logic [CNT_W-1:0]  meas_count;
    logic [CNT_W:0]    diff;
    logic              vreg_ok;

    assign vreg_ok = &i_vreg_rdy;

    aibcr3aux_osc_cal_meas #(
        .WIN_CYC (WIN_CYC),
        .CNT_W   (CNT_W)
    ) u_meas (
        .clk     (iclk),
        .rst     (irst),
        .start   (meas_start),
        .abort   (meas_abort),
        .osc_tgl (i_osc_tgl),
        .done    (meas_done),
        .count   (meas_count)
    );

    // One bit wider than the count so the absolute error never wraps
    assign diff = (meas_cnt_q >= i_target) ? ({1'b0, meas_cnt_q} - {1'b0, i_target})
                                           : ({1'b0, i_target} - {1'b0, meas_cnt_q});

    always_comb begin
        state_d    = state_q;
        pdb_d      = pdb_q;
        trim_d     = trim_q;
        trim_next  = trim_q;
        rdy_dly_d  = rdy_dly_q;
        done_d     = done_q;
        fail_d     = fail_q;
        meas_cnt_d = meas_cnt_q;
        bit_d      = bit_q;
        verify_d   = verify_q;
        bypass_d   = bypass_q;
        tmr_d      = tmr_q;
        meas_start = 1'b0;
        meas_abort = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (state_q == ST_DONE) rdy_dly_d = 1'b1;
                if (state_q == ST_FAIL) rdy_dly_d = 1'b0;
                if (i_cal_start) begin
                    state_d   = ST_PWRUP;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    rdy_dly_d = 1'b0;
                    pdb_d     = 1'b1;
                    bit_d     = 4'(TRIM_W - 1);
                    bypass_d  = i_fuse_bypass;
                    verify_d  = i_fuse_bypass;
                    trim_d    = i_fuse_bypass ? i_fuse_trim : TRIM_MID;
                    tmr_d     = '0;
                end
            end
            ST_PWRUP: begin
                if (vreg_ok) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(VREG_TO - 1)) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!vreg_ok) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    state_d    = ST_MEAS;
                    meas_start = 1'b1;
                    tmr_d      = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_MEAS: begin
                if (!vreg_ok) begin
                    state_d    = ST_FAIL;
                    fail_d     = 1'b1;
                    meas_abort = 1'b1;
                end else if (meas_done) begin
                    state_d    = ST_DECIDE;
                    meas_cnt_d = meas_count;
                end
            end
            ST_DECIDE: begin
                if (!vreg_ok) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else if (verify_q) begin
                    if (diff <= (CNT_W + 1)'(i_tol)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end
                end else begin
                    // Higher code runs faster, so a high count drops the bit under test
                    if (meas_cnt_q > i_target) trim_next[bit_q] = 1'b0;
                    if (bit_q != 4'd0) begin
                        trim_next[bit_q - 4'd1] = 1'b1;
                        bit_d = bit_q - 4'd1;
                    end else begin
                        verify_d = 1'b1;
                    end
                    trim_d  = trim_next;
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= ST_IDLE;
            pdb_q      <= 1'b0;
            trim_q     <= '0;
            rdy_dly_q  <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            meas_cnt_q <= '0;
            bit_q      <= '0;
            verify_q   <= 1'b0;
            bypass_q   <= 1'b0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pdb_q      <= pdb_d;
            trim_q     <= trim_d;
            rdy_dly_q  <= rdy_dly_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            meas_cnt_q <= meas_cnt_d;
            bit_q      <= bit_d;
            verify_q   <= verify_d;
            bypass_q   <= bypass_d;
            tmr_q      <= tmr_d;
        end
    end

    assign o_pdb      = pdb_q;
    assign o_trim     = trim_q;
    assign o_rdy_dly  = rdy_dly_q;
    assign o_busy     = is_busy(state_q);
    assign o_done     = done_q;
    assign o_fail     = fail_q;
    assign o_meas_cnt = meas_cnt_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_aibcr3aux_osc_cal_ctrl.sv
// Directed bench for the AUX oscillator calibration sequencer; the oscillator is
// modelled as an NCO whose edges per 1024-cycle window equal trim + 321.
module tb_aibcr3aux_osc_cal_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_PWRUP = 3'd1, S_MEAS = 3'd3;
    localparam logic [2:0] S_DONE = 3'd5, S_FAIL = 3'd6;
    localparam int LAT_BYPASS = 1 + 1 + 64 + 1024 + 1;
    localparam int LAT_SEARCH = 1 + 1 + 10 * (64 + 1024 + 1);
    localparam int LAT_VREG_TO = 1 + 4096;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        i_cal_start = 1'b0;
    logic        i_fuse_bypass = 1'b0;
    logic [8:0]  i_fuse_trim = 9'h000;
    logic [15:0] i_target = 16'd500;
    logic [7:0]  i_tol = 8'd4;
    logic [2:0]  i_vreg_rdy = 3'b111;
    logic        osc_tgl = 1'b0;
    logic        o_pdb, o_rdy_dly, o_busy, o_done, o_fail;
    logic [8:0]  o_trim;
    logic [15:0] o_meas_cnt;
    logic [2:0]  o_state;

    logic [7:0]  i_target2 = 8'd200;
    logic        osc2 = 1'b0;
    logic        o_pdb2, o_rdy_dly2, o_busy2, o_done2, o_fail2;
    logic [8:0]  o_trim2;
    logic [7:0]  o_meas_cnt2;
    logic [2:0]  o_state2;

    logic [9:0]  acc = 10'd0;
    logic [10:0] nsum;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 iclk = ~iclk;

    aibcr3aux_osc_cal_ctrl dut (
        .iclk(iclk), .irst(irst), .i_cal_start(i_cal_start), .i_fuse_bypass(i_fuse_bypass),
        .i_fuse_trim(i_fuse_trim), .i_target(i_target), .i_tol(i_tol), .i_vreg_rdy(i_vreg_rdy),
        .i_osc_tgl(osc_tgl), .o_pdb(o_pdb), .o_trim(o_trim), .o_rdy_dly(o_rdy_dly),
        .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_meas_cnt(o_meas_cnt),
        .o_state(o_state)
    );

    // Narrow-counter instance fed one edge per cycle, so its window count saturates
    aibcr3aux_osc_cal_ctrl #(.CNT_W(8)) dut_sat (
        .iclk(iclk), .irst(irst), .i_cal_start(i_cal_start), .i_fuse_bypass(i_fuse_bypass),
        .i_fuse_trim(i_fuse_trim), .i_target(i_target2), .i_tol(i_tol), .i_vreg_rdy(i_vreg_rdy),
        .i_osc_tgl(osc2), .o_pdb(o_pdb2), .o_trim(o_trim2), .o_rdy_dly(o_rdy_dly2),
        .o_busy(o_busy2), .o_done(o_done2), .o_fail(o_fail2), .o_meas_cnt(o_meas_cnt2),
        .o_state(o_state2)
    );

    assign nsum = {1'b0, acc} + 11'(o_trim) + 11'd321;

    always @(negedge iclk) begin
        acc  <= nsum[9:0];
        if (nsum[10]) osc_tgl <= ~osc_tgl;
        osc2 <= ~osc2;
    end

    task automatic tick();
        @(posedge iclk);
        @(negedge iclk);
        cyc++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        i_cal_start = 1'b1;
        tick();
        i_cal_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (o_state == st) break;
            tick();
        end
    endtask

    task automatic apply_stimulus_bypass(input string tag, input logic [8:0] fuse,
                                         input logic [2:0] end_st, input int exp_cnt);
        i_fuse_bypass = 1'b1;
        i_fuse_trim   = fuse;
        cyc = 0;
        pulse_start();
        check_output({tag, "_entry_trim"}, 32'(o_trim), 32'(fuse));
        wait_state(end_st, 1500);
        check_output({tag, "_latency"}, 32'(cyc), 32'(LAT_BYPASS));
        check_output({tag, "_state"}, 32'(o_state), 32'(end_st));
        check_output({tag, "_meas_cnt"}, 32'(o_meas_cnt), 32'(exp_cnt));
        check_output({tag, "_trim"}, 32'(o_trim), 32'(fuse));
        check_output({tag, "_done"}, 32'(o_done), (end_st == S_DONE) ? 32'd1 : 32'd0);
        check_output({tag, "_fail_flag"}, 32'(o_fail), (end_st == S_FAIL) ? 32'd1 : 32'd0);
        tick();
        check_output({tag, "_rdy_dly"}, 32'(o_rdy_dly), (end_st == S_DONE) ? 32'd1 : 32'd0);
        check_output({tag, "_pdb"}, 32'(o_pdb), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        check_output("rst_state", 32'(o_state), 32'(S_IDLE));
        check_output("rst_trim", 32'(o_trim), 32'h000);
        check_output("rst_pdb", 32'(o_pdb), 32'd0);
        check_output("rst_busy", 32'(o_busy), 32'd0);
        check_output("rst_flags", 32'({o_done, o_fail, o_rdy_dly}), 32'd0);
        check_output("rst_meas_cnt", 32'(o_meas_cnt), 32'd0);
        irst = 1'b0;
        tick();

        // Full search; a start pulse in the middle must not restart it
        cyc = 0;
        pulse_start();
        check_output("t1_entry_state", 32'(o_state), 32'(S_PWRUP));
        check_output("t1_entry_trim", 32'(o_trim), 32'h100);
        check_output("t1_entry_pdb", 32'(o_pdb), 32'd1);
        check_output("t1_entry_busy", 32'(o_busy), 32'd1);
        repeat (3000) tick();
        pulse_start();
        wait_state(S_DONE, 12000);
        check_output("t1_latency", 32'(cyc), 32'(LAT_SEARCH));
        check_output("t1_trim", 32'(o_trim), 32'h0B3);
        check_output("t1_meas_cnt", 32'(o_meas_cnt), 32'd500);
        check_output("t1_done", 32'(o_done), 32'd1);
        check_output("t1_rdy_early", 32'(o_rdy_dly), 32'd0);
        tick();
        check_output("t1_rdy_dly", 32'(o_rdy_dly), 32'd1);
        check_output("t1_busy", 32'(o_busy), 32'd0);
        check_output("t1_pdb", 32'(o_pdb), 32'd1);

        check_output("t5_state", 32'(o_state2), 32'(S_FAIL));
        check_output("t5_meas_sat", 32'(o_meas_cnt2), 32'hFF);
        check_output("t5_trim", 32'(o_trim2), 32'h000);
        check_output("t5_fail_flag", 32'(o_fail2), 32'd1);

        // Restart from DONE, then reset in the middle of the measurement
        pulse_start();
        check_output("t6_restart_state", 32'(o_state), 32'(S_PWRUP));
        check_output("t6_restart_done", 32'(o_done), 32'd0);
        check_output("t6_restart_rdy", 32'(o_rdy_dly), 32'd0);
        check_output("t6_restart_trim", 32'(o_trim), 32'h100);
        wait_state(S_MEAS, 200);
        check_output("t6_in_meas", 32'(o_state), 32'(S_MEAS));
        repeat (10) tick();
        irst = 1'b1;
        tick();
        irst = 1'b0;
        check_output("t6_rst_state", 32'(o_state), 32'(S_IDLE));
        check_output("t6_rst_pdb", 32'(o_pdb), 32'd0);
        check_output("t6_rst_trim", 32'(o_trim), 32'h000);
        check_output("t6_rst_outs", 32'({o_busy, o_done, o_fail, o_rdy_dly}), 32'd0);
        check_output("t6_rst_meas_cnt", 32'(o_meas_cnt), 32'd0);

        apply_stimulus_bypass("t2_fuse_b3", 9'h0B3, S_DONE, 500);
        apply_stimulus_bypass("t2_fuse_00", 9'h000, S_FAIL, 321);
        apply_stimulus_bypass("t2_tol_hi_edge", 9'h0B7, S_DONE, 504);
        apply_stimulus_bypass("t2_tol_hi_out", 9'h0B8, S_FAIL, 505);
        apply_stimulus_bypass("t2_tol_lo_edge", 9'h0AF, S_DONE, 496);

        // Regulator drop during the window aborts without touching the last count
        i_fuse_trim = 9'h0B3;
        pulse_start();
        wait_state(S_MEAS, 200);
        repeat (200) tick();
        i_vreg_rdy = 3'b101;
        tick();
        check_output("t4_state", 32'(o_state), 32'(S_FAIL));
        check_output("t4_fail_flag", 32'(o_fail), 32'd1);
        check_output("t4_meas_kept", 32'(o_meas_cnt), 32'd496);
        check_output("t4_busy", 32'(o_busy), 32'd0);
        check_output("t4_pdb", 32'(o_pdb), 32'd1);
        i_vreg_rdy = 3'b111;
        tick();
        apply_stimulus_bypass("t4_rerun", 9'h0B3, S_DONE, 500);

        // Regulators never ready
        i_vreg_rdy    = 3'b011;
        i_fuse_bypass = 1'b0;
        cyc = 0;
        pulse_start();
        wait_state(S_FAIL, 5000);
        check_output("t3_latency", 32'(cyc), 32'(LAT_VREG_TO));
        check_output("t3_state", 32'(o_state), 32'(S_FAIL));
        check_output("t3_busy", 32'(o_busy), 32'd0);
        check_output("t3_pdb", 32'(o_pdb), 32'd1);
        check_output("t3_fail_flag", 32'(o_fail), 32'd1);
        check_output("t3_trim", 32'(o_trim), 32'h100);
        tick();
        check_output("t3_rdy_dly", 32'(o_rdy_dly), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
